vertical_count: RTL

//  Vertical timing stage of the VGA pipeline, directly downstream of the horizontal counter.

---
 rtl/vertical_count.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vertical_count.sv
// Vertical timing stage: advances a line counter on each completed horizontal line and
// decodes vsync, vertical enable, visible row and frame strobes. Optional macro VCOUNT_LINE_CHECK_EN.
module vertical_count #(
    parameter logic [10:0] WHOLE_LINE   = 11'd800,
    parameter logic [10:0] SYNC_PULSE   = 11'd2,
    parameter logic [10:0] BACK_PORCH   = 11'd33,
    parameter logic [10:0] VISIBLE_AREA = 11'd480,
    parameter logic [10:0] FRONT_PORCH  = 11'd10,
    parameter logic [10:0] WHOLE_FRAME  = 11'd525
) (
    input  logic        slow_clock,
    input  logic        reset_n,
    input  logic [10:0] in_horizontal_counter,
    output logic [10:0] out_vertical_counter,
    output logic        vsync,
    output logic        enable_display_vertically,
    output logic [9:0]  visible_row,
    output logic        frame_start,
    output logic [7:0]  frame_count,
    output logic        line_error
);

    localparam logic [10:0] VIS_FIRST = SYNC_PULSE + BACK_PORCH;
    localparam logic [10:0] VIS_END   = VIS_FIRST + VISIBLE_AREA;

    logic        line_end_s;
    logic        wrap_s;
    logic [10:0] vnext_s;
    logic        vsync_next_s;
    logic        enable_next_s;
    logic [10:0] row_diff_s;
    logic [9:0]  row_next_s;

    logic [10:0] vcount_r;
    logic        vsync_r;
    logic        enable_r;
    logic [9:0]  row_r;
    logic        frame_start_r;
    logic [7:0]  frame_count_r;

    // Next line value and the decodes taken from it, so outputs move with the counter.
    always_comb begin
        line_end_s = (in_horizontal_counter == (WHOLE_LINE - 11'd1));
        wrap_s     = line_end_s && (vcount_r == (WHOLE_FRAME - 11'd1));
        if (wrap_s) begin
            vnext_s = 11'd0;
        end else if (line_end_s) begin
            vnext_s = vcount_r + 11'd1;
        end else begin
            vnext_s = vcount_r;
        end
        vsync_next_s  = (vnext_s >= SYNC_PULSE);
        enable_next_s = (vnext_s >= VIS_FIRST) && (vnext_s < VIS_END);
        row_diff_s    = vnext_s - VIS_FIRST;
        if (enable_next_s) begin
            row_next_s = row_diff_s[9:0];
        end else begin
            row_next_s = 10'd0;
        end
    end

    // Line counter, frame counter and registered vertical outputs.
    always_ff @(posedge slow_clock or negedge reset_n) begin
        if (!reset_n) begin
            vcount_r      <= 11'd0;
            vsync_r       <= 1'b0;
            enable_r      <= 1'b0;
            row_r         <= 10'd0;
            frame_start_r <= 1'b0;
            frame_count_r <= 8'd0;
        end else begin
            vcount_r      <= vnext_s;
            vsync_r       <= vsync_next_s;
            enable_r      <= enable_next_s;
            row_r         <= row_next_s;
            frame_start_r <= wrap_s;
            if (wrap_s) begin
                frame_count_r <= frame_count_r + 8'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign out_vertical_counter      = vcount_r;
    assign vsync                     = vsync_r;
    assign enable_display_vertically = enable_r;
    assign visible_row               = row_r;
    assign frame_start               = frame_start_r;
    assign frame_count               = frame_count_r;

`ifdef VCOUNT_LINE_CHECK_EN
    logic [10:0] prev_h_r;
    logic        prev_valid_r;
    logic        line_error_r;
    logic [10:0] expected_h_s;

    // The horizontal stage must step by one and wrap at end of line.
    always_comb begin
        if (prev_h_r == (WHOLE_LINE - 11'd1)) begin
            expected_h_s = 11'd0;
        end else begin
            expected_h_s = prev_h_r + 11'd1;
        end
    end

    // Sticky continuity error; the first cycle after reset has no history to compare.
    always_ff @(posedge slow_clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_h_r     <= 11'd0;
            prev_valid_r <= 1'b0;
            line_error_r <= 1'b0;
        end else begin
            prev_h_r     <= in_horizontal_counter;
            prev_valid_r <= 1'b1;
            if (prev_valid_r && (in_horizontal_counter != expected_h_s)) begin
                line_error_r <= 1'b1;
            end else begin
                line_error_r <= line_error_r;
            end
        end
    end

    assign line_error = line_error_r;
`else
    assign line_error = 1'b0;
`endif

endmodule
